// File: rtl/demux_pkg.sv
// Shared types and constants for the packet-aware 1-to-4 demux router.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // IDLE: next accepted beat starts a packet; PKT: mid-packet, route is locked
    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    // The route for the current beat: live select between packets, latched select inside one
    function automatic logic [SEL_W-1:0] active_ch(
        input state_t           state,
        input logic [SEL_W-1:0] live_sel,
        input logic [SEL_W-1:0] held_sel
    );
        return (state == IDLE) ? live_sel : held_sel;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One registered output channel (valid/data/last) of the demux router.
// Latency: 1 cycle from i_load to o_valid/o_data/o_last.
// Backpressure: o_free is low only while full and i_ready is low; data/last hold until drained.
module demux_out_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_free
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;

    // A slot can take a beat when empty or when its current beat leaves this cycle
    assign o_free  = !r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    // Load wins over drain so a simultaneous drain+load keeps the slot valid at full rate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_pkt_router.sv
// Packet-aware 1-to-4 demux: routes whole packets by the select sampled on the first beat.
// Latency: 1 cycle input beat to output register; one beat per cycle per channel.
// Backpressure: in_ready mirrors the free state of the active channel; no redirect while stalled.
// Optional per-channel saturating beat counters are built when DEMUX_BEAT_CNT_EN is defined.
module demux_pkt_router
    import demux_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_last,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [NUM_CH-1:0]    out_last,
    output logic                 pkt_active
`ifdef DEMUX_BEAT_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] beat_cnt
`endif
);

    state_t           r_state;
    logic [SEL_W-1:0] r_cur_sel;
    logic             r_pkt_active;

    logic [SEL_W-1:0] w_ch;
    logic [NUM_CH-1:0] w_slot_free;
    logic [NUM_CH-1:0] w_load;
    logic              w_accept;

    // Route is locked to the first-beat select for the rest of the packet
    assign w_ch       = active_ch(r_state, in_sel, r_cur_sel);
    assign in_ready   = w_slot_free[w_ch];
    assign w_accept   = in_valid & in_ready;
    assign pkt_active = r_pkt_active;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
            assign w_load[g] = w_accept && (w_ch == SEL_W'(g));

            demux_out_slot #(
                .DW (DW)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load[g]),
                .i_data  (in_data),
                .i_last  (in_last),
                .i_ready (out_ready[g]),
                .o_valid (out_valid[g]),
                .o_data  (out_data[g*DW +: DW]),
                .o_last  (out_last[g]),
                .o_free  (w_slot_free[g])
            );
        end
    endgenerate

    // Packet framing: enter PKT on a non-last first beat, leave on the accepted last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur_sel    <= '0;
            r_pkt_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && !in_last) begin
                        r_state      <= PKT;
                        r_cur_sel    <= in_sel;
                        r_pkt_active <= 1'b1;
                    end
                end
                PKT: begin
                    if (w_accept && in_last) begin
                        r_state      <= IDLE;
                        r_pkt_active <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pkt_active <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEMUX_BEAT_CNT_EN
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Count accepted beats per channel, sticking at all-ones instead of wrapping
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_load[c] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign beat_cnt[c*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate
`endif

endmodule

// File: doc/demux_pkt_router.md
Name: demux_pkt_router

Overview:
- Sequential, packet-aware front end for the 1-to-4 demux path. Takes one valid/ready stream of data beats with a 2-bit destination select and routes whole packets to one of 4 registered output channels.
- Select is sampled on the first beat of a packet and held until the last beat, so a packet is never split across channels.
- Sits directly upstream of the 4 consumer lanes; plays the same role as the combinational demux, but adds handshakes and storage.

Parameters:
- DW, 8, data beat width in bits.
- CNT_W, 16, width of each per-channel beat counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous assert, active-high.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  router can accept the beat this cycle.
- in_data  input  DW  beat payload.
- in_sel  input  2  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  final beat of the packet.
- out_valid  output  4  per-channel output register holds a beat.
- out_ready  input  4  per-channel downstream ready.
- out_data  output  4*DW  channel i occupies bits [i*DW +: DW].
- out_last  output  4  per-channel last flag.
- pkt_active  output  1  high while a multi-beat packet is in flight (state PKT).

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_last=0.
  - state=IDLE, cur_sel=0, pkt_active=0.
  - in_ready follows its combinational equation; with all out_valid=0 it evaluates to 1.
- Active channel: ch = (state==IDLE) ? in_sel : cur_sel.
- in_ready = !out_valid[ch] | out_ready[ch]. This is a combinational pass-through; no dependence on in_valid.
- Accept = in_valid & in_ready. On accept:
  - out_data[ch] <= in_data, out_last[ch] <= in_last, out_valid[ch] <= 1.
  - Latency in→out is 1 cycle.
- Channel drain: out_valid[i] & out_ready[i] with no new accept to i → out_valid[i] <= 0. Data and last hold their last value.
- Simultaneous drain and accept on the same channel: the register reloads and out_valid stays 1. Full throughput is 1 beat/cycle per channel.
- Channels not equal to ch are untouched. Other channels drain independently in parallel.
- FSM:
  - IDLE: accept with in_last=0 → cur_sel <= in_sel, go to PKT. Accept with in_last=1 (single-beat packet) → stay IDLE.
  - PKT: in_sel is ignored. Accept with in_last=1 → IDLE. Otherwise stay in PKT.
- pkt_active = (state==PKT).
- A stall in PKT (target channel full) holds in_ready=0 and does not redirect, even if in_sel changes.
- Reset mid-packet: state returns to IDLE immediately and all output registers clear. The remaining beats of that packet are then treated as a new packet.
- Backpressure rule: out_data/out_last must stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: DEMUX_BEAT_CNT_EN.
- Defined:
  - Extra output port beat_cnt, 4*CNT_W wide.
  - Per-channel counter increments on each accepted beat to that channel.
  - Saturates at all-ones; no wrap.
  - Cleared by rst only.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4 and SEL_W=2.
  - Enum state_t {IDLE, PKT}.
- Sub-module demux_out_slot: one output register with valid/ready, data and last. Instantiated 4× in a generate loop. Holds the load/drain/simultaneous logic in one place.

Test Plan:
- Reset with in_valid=1 → all out_valid=0, in_ready=1, pkt_active=0. Release rst, send single beat data=0xA5, sel=2, last=1 → next cycle out_valid=4'b0100, out_data[23:16]=0xA5, out_last[2]=1.
- 3-beat packet 0x11, 0x22, 0x33 with sel=1 on beat 1 and in_sel changed to 3 on beats 2–3, out_ready=4'hF → all three beats appear on channel 1 only. pkt_active=1 after beat 1 and 0 after beat 3.
- Channel 0 full with out_ready[0]=0, next beat sel=0 → in_ready=0 and beat held. Raise out_ready[0] → beat accepted the same cycle, out_valid[0] stays 1, new data visible next cycle.
- Back-to-back single beats sel=0,1,2,3,0 with out_ready=4'hF → one accept per cycle, each output valid exactly one cycle after its input.
- Assert rst mid-packet (after beat 2 of 4 to channel 3) → pkt_active=0 and out_valid=0 asynchronously. Next beat with sel=0 routes to channel 0.
- DEMUX_BEAT_CNT_EN with CNT_W=4: send 20 beats to channel 2 → beat_cnt[11:8]=4'hF (saturated), other counters 0.
